// File: rtl/line_refill_pkg.sv
// Shared types and helpers for the line-refill backing memory.
package line_refill_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, FILL, RESP} state_e;

    function automatic int line_words(input int byte_offset_bits);
        return (1 << byte_offset_bits) >> 2;
    endfunction

endpackage

// File: rtl/word_ram.sv
// Word array behind the refill port: synchronous load write, combinational fill read.
module word_ram #(
    parameter int AddrBits = 12
) (
    input  logic                clk_i,
    input  logic                i_we,
    input  logic [AddrBits-1:0] i_waddr,
    input  logic [31:0]         i_wdata,
    input  logic [AddrBits-1:0] i_raddr,
    output logic [31:0]         o_rdata
);

    logic [31:0] r_mem [2**AddrBits];

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A read of the word being written this cycle sees the old contents.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/line_refill_memory.sv
// Instruction-cache refill responder: waits Latency cycles, gathers one line word by word,
// then presents it with a one-cycle valid pulse.
module line_refill_memory
    import line_refill_pkg::*;
#(
    parameter int ByteOffsetBits = 5,
    parameter int MemWordsBits   = 12,
    parameter int Latency        = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rstn_i,
    input  logic [31:0]                                  mem_addr_i,
    input  logic                                         mem_read_en_i,
    output logic                                         mem_read_valid_o,
    output logic [32*line_words(ByteOffsetBits)-1:0]     mem_read_data_o,
    input  logic                                         load_en_i,
    input  logic [31:0]                                  load_addr_i,
    input  logic [31:0]                                  load_data_i,
    output logic                                         busy_o
);

    localparam int NrWordsPerLine = line_words(ByteOffsetBits);
    localparam int LineSize       = 32 * NrWordsPerLine;
    localparam int WordSelBits    = ByteOffsetBits - 2;
    localparam int CntBits        = (Latency > 1) ? $clog2(Latency) : 1;
    localparam logic [CntBits-1:0]     LatInit  = (Latency > 0) ? CntBits'(Latency - 1) : '0;
    localparam logic [WordSelBits-1:0] LastWord = WordSelBits'(NrWordsPerLine - 1);

    state_e                  r_state;
    logic [CntBits-1:0]      r_lat_cnt;
    logic [WordSelBits-1:0]  r_word_cnt;
    logic [MemWordsBits-1:0] r_base;
    logic [LineSize-1:0]     r_line;

    logic [MemWordsBits-1:0] w_rd_addr;
    logic [31:0]             w_rd_data;
    logic                    w_unused_addr;

    // Byte-offset and out-of-range address bits are intentionally dropped (index wraps).
    assign w_unused_addr = ^{mem_addr_i[31:MemWordsBits+2], mem_addr_i[ByteOffsetBits-1:0],
                             load_addr_i[31:MemWordsBits+2], load_addr_i[1:0]};

    assign w_rd_addr = r_base + MemWordsBits'(r_word_cnt);

    word_ram #(
        .AddrBits (MemWordsBits)
    ) u_word_ram (
        .clk_i   (clk_i),
        .i_we    (load_en_i),
        .i_waddr (load_addr_i[MemWordsBits+1:2]),
        .i_wdata (load_data_i),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_lat_cnt  <= '0;
            r_word_cnt <= '0;
            r_base     <= '0;
            r_line     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_read_en_i) begin
                        r_base     <= {mem_addr_i[MemWordsBits+1:ByteOffsetBits], {WordSelBits{1'b0}}};
                        r_lat_cnt  <= LatInit;
                        r_word_cnt <= '0;
                        r_state    <= (Latency == 0) ? FILL : WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_read_en_i) begin
                        r_state <= IDLE;
                    end else if (r_lat_cnt == '0) begin
                        r_word_cnt <= '0;
                        r_state    <= FILL;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                FILL: begin
                    // An abort leaves whatever part of the line was already gathered.
                    if (!mem_read_en_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_line[32*r_word_cnt +: 32] <= w_rd_data;
                        r_word_cnt                  <= r_word_cnt + 1'b1;
                        if (r_word_cnt == LastWord) begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_read_valid_o = (r_state == RESP);
    assign busy_o           = (r_state != IDLE);
    assign mem_read_data_o  = r_line;

endmodule

// File: tb/tb_line_refill_memory.sv
// Randomized bench for line_refill_memory (Latency=4 and Latency=0 instances) against an array model.
module tb_line_refill_memory;

    localparam int NW    = 8;
    localparam int DEPTH = 4096;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         req_en   [2];
    logic [31:0]  req_addr [2];
    logic         vld      [2];
    logic [255:0] data     [2];
    logic         bsy      [2];
    logic         load_en = 1'b0;
    logic [31:0]  load_addr = '0;
    logic [31:0]  load_data = '0;

    logic [31:0]  mem_model [DEPTH];
    int           n_checks = 0;
    int           n_pass = 0;

    always #5 clk_i = ~clk_i;

    line_refill_memory #(.ByteOffsetBits(5), .MemWordsBits(12), .Latency(4)) u_dut_lat4 (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .mem_addr_i       (req_addr[0]),
        .mem_read_en_i    (req_en[0]),
        .mem_read_valid_o (vld[0]),
        .mem_read_data_o  (data[0]),
        .load_en_i        (load_en),
        .load_addr_i      (load_addr),
        .load_data_i      (load_data),
        .busy_o           (bsy[0])
    );

    line_refill_memory #(.ByteOffsetBits(5), .MemWordsBits(12), .Latency(0)) u_dut_lat0 (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .mem_addr_i       (req_addr[1]),
        .mem_read_en_i    (req_en[1]),
        .mem_read_valid_o (vld[1]),
        .mem_read_data_o  (data[1]),
        .load_en_i        (load_en),
        .load_addr_i      (load_addr),
        .load_data_i      (load_data),
        .busy_o           (bsy[1])
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] val);
        load_en   = 1'b1;
        load_addr = 32'(idx) << 2;
        load_data = val;
        tick();
        mem_model[idx] = val;
        load_en = 1'b0;
    endtask

    // Model: valid at cycle Latency+NW+1; word k of the line is whatever the array holds
    // at the start of fill cycle Latency+1+k (same-cycle loads land afterwards).
    task automatic run_req(input int d, input logic [31:0] addr, input int drop_at, input bit rand_loads);
        int lat = (d == 0) ? 4 : 0;
        int vc = lat + NW + 1;
        int base = ((int'(addr) >>> 2) & (DEPTH - 1)) & ~(NW - 1);
        logic [255:0] exp_line = '0;
        int la = 0;
        req_en[d]   = 1'b1;
        req_addr[d] = addr;
        for (int c = 0; c <= vc + 1; c++) begin
            check_eq($sformatf("valid d%0d c%0d", d, c), 256'(vld[d]), 256'(drop_at < 0 && c == vc));
            check_eq($sformatf("busy d%0d c%0d", d, c), 256'(bsy[d]),
                     256'(c >= 1 && c <= vc && (drop_at < 0 || c <= drop_at)));
            if (drop_at < 0 && c == vc) begin
                check_eq($sformatf("line d%0d a%h", d, addr), data[d], exp_line);
            end
            if (c >= lat + 1 && c <= lat + NW) begin
                exp_line[32*(c-lat-1) +: 32] = mem_model[(base + c - lat - 1) % DEPTH];
            end
            if (c == drop_at || c == vc) req_en[d] = 1'b0;
            if (c >= 1) req_addr[d] = $urandom;
            if (rand_loads && $urandom_range(0, 2) == 0) begin
                la        = (base + int'($urandom_range(0, NW - 1))) % DEPTH;
                load_en   = 1'b1;
                load_addr = 32'(la) << 2;
                load_data = $urandom;
            end else begin
                load_en = 1'b0;
            end
            tick();
            if (load_en) mem_model[la] = load_data;
        end
        load_en = 1'b0;
    endtask

    initial begin
        req_en[0] = 1'b0; req_en[1] = 1'b0;
        req_addr[0] = '0; req_addr[1] = '0;

        // Preload while in reset: the array has no reset and must still accept loads.
        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
        for (int i = 0; i < NW; i++) load_word(32'h20 + i, 32'hA000_0000 + i);
        check_eq("rst_valid", 256'(vld[0]), 256'(0));
        check_eq("rst_busy", 256'(bsy[0]), 256'(0));
        check_eq("rst_data", data[0], 256'(0));
        rstn_i = 1'b1;
        tick();

        run_req(0, 32'h0000_0080, -1, 1'b0);
        check_eq("line80_w0", 256'(data[0][31:0]), 256'(32'hA000_0000));
        check_eq("line80_w7", 256'(data[0][255:224]), 256'(32'hA000_0007));
        run_req(0, 32'h0000_009C, -1, 1'b0);
        run_req(0, 32'h0000_0080, 6, 1'b0);
        run_req(0, 32'h0000_0080, -1, 1'b0);

        // Latency 0, request held past RESP: recaptured only after the IDLE cycle.
        req_en[1] = 1'b1;
        req_addr[1] = 32'h0000_0080;
        for (int c = 0; c <= 11; c++) begin
            check_eq($sformatf("hold valid c%0d", c), 256'(vld[1]), 256'(c == 9));
            check_eq($sformatf("hold busy c%0d", c), 256'(bsy[1]), 256'((c >= 1 && c <= 9) || c == 11));
            if (c == 9) check_eq("hold w3", 256'(data[1][127:96]), 256'(32'hA000_0003));
            if (c == 11) req_en[1] = 1'b0;
            tick();
        end
        tick();

        run_req(0, 32'h0000_4080, -1, 1'b0);
        check_eq("wrap_w5", 256'(data[0][191:160]), 256'(32'hA000_0005));
        run_req(1, 32'h0000_4080, -1, 1'b0);

        // Reset in cycle 10, released in cycle 11.
        req_en[0] = 1'b1;
        req_addr[0] = 32'h0000_0080;
        for (int c = 0; c < 10; c++) tick();
        rstn_i = 1'b0;
        req_en[0] = 1'b0;
        #1;
        check_eq("rstmid_data", data[0], 256'(0));
        check_eq("rstmid_valid", 256'(vld[0]), 256'(0));
        check_eq("rstmid_busy", 256'(bsy[0]), 256'(0));
        tick();
        rstn_i = 1'b1;
        for (int c = 0; c < 15; c++) begin
            check_eq($sformatf("postrst valid c%0d", c), 256'(vld[0]), 256'(0));
            check_eq($sformatf("postrst busy c%0d", c), 256'(bsy[0]), 256'(0));
            tick();
        end
        run_req(0, 32'h0000_0080, -1, 1'b0);

        for (int it = 0; it < 40; it++) begin
            int d = int'($urandom_range(0, 1));
            int vc = ((d == 0) ? 4 : 0) + NW + 1;
            int drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, vc - 1)) : -1;
            run_req(d, $urandom, drop, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
